// File: rtl/mul_div_unit_pkg.sv
// ============================================================================
// Module  : otter_pkg
// Brief   : Shared M-extension encodings, MDU state enum and timing constants.
// Revision: 1.0
// ============================================================================
`default_nettype none

package otter_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int MDU_ITER    = 32;
    localparam int MDU_LATENCY = 34;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_CALC = 2'd2,
        ST_FIN  = 2'd3
    } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mul_div_unit_if.sv
// ============================================================================
// Module  : mul_div_unit_if
// Brief   : Request / write-back bundle between the pipeline and the MDU.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mul_div_unit_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_addr;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        w_en;
    logic [4:0]  w_addr;

    modport master (
        output start, funct3, op_a, op_b, rd_addr,
        input  busy, done, result, w_en, w_addr
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_addr,
        output busy, done, result, w_en, w_addr
    );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ============================================================================
// Module  : mul_div_unit
// Brief   : RV32M multiply/divide unit, fixed 34-cycle latency, shared 64-bit
//           accumulator for shift-add multiply and restoring divide.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mul_div_unit
    import otter_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    mul_div_unit_if.slave   bus
);

    mdu_state_t  state;
    logic [5:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] mag_b;
    logic [63:0] acc;
    logic        neg_lo;
    logic        neg_rem;
    logic        busy_q;
    logic        done_q;
    logic [31:0] result_q;
    logic [4:0]  w_addr_q;

    logic        is_div;
    logic        signed_a;
    logic        signed_b;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a_w;
    logic [31:0] mag_b_w;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [63:0] div_next;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;
    logic [31:0] sel;

    assign is_div   = op_q[2];
    assign signed_a = (op_q == F3_MULH) || (op_q == F3_MULHSU) ||
                      (op_q == F3_DIV)  || (op_q == F3_REM);
    assign signed_b = (op_q == F3_MULH) || (op_q == F3_DIV) || (op_q == F3_REM);
    assign a_neg    = signed_a & a_q[31];
    assign b_neg    = signed_b & b_q[31];
    assign mag_a_w  = a_neg ? (32'd0 - a_q) : a_q;
    assign mag_b_w  = b_neg ? (32'd0 - b_q) : b_q;

    // Multiply: acc = {partial_hi, multiplier}, add then shift right.
    assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_b} : 33'd0);
    assign mul_next = {mul_sum, acc[31:1]};

    // Divide: acc = {remainder, dividend/quotient}; shifted remainder needs 33 bits.
    assign div_shift = acc[63:31];
    assign div_diff  = div_shift - {1'b0, mag_b};
    assign div_next  = div_diff[32] ? {div_shift[31:0], acc[30:0], 1'b0}
                                    : {div_diff[31:0],  acc[30:0], 1'b1};

    assign prod     = neg_lo  ? (64'd0 - acc)         : acc;
    assign quot     = neg_lo  ? (32'd0 - acc[31:0])   : acc[31:0];
    assign rem      = neg_rem ? (32'd0 - acc[63:32])  : acc[63:32];
    assign div_zero = (b_q == 32'd0);

    always_comb begin
        sel = 32'd0;
        case (op_q)
            F3_MUL:                       sel = prod[31:0];
            F3_MULH, F3_MULHSU, F3_MULHU: sel = prod[63:32];
            F3_DIV, F3_DIVU:              sel = div_zero ? 32'hFFFF_FFFF : quot;
            default:                      sel = div_zero ? a_q : rem;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 6'd0;
            op_q     <= 3'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            mag_b    <= 32'd0;
            acc      <= 64'd0;
            neg_lo   <= 1'b0;
            neg_rem  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'd0;
            w_addr_q <= 5'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        op_q     <= bus.funct3;
                        a_q      <= bus.op_a;
                        b_q      <= bus.op_b;
                        w_addr_q <= bus.rd_addr;
                        busy_q   <= 1'b1;
                        state    <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    mag_b   <= mag_b_w;
                    acc     <= {32'd0, mag_a_w};
                    neg_lo  <= a_neg ^ b_neg;
                    neg_rem <= a_neg;
                    cnt     <= 6'(MDU_ITER);
                    state   <= ST_CALC;
                end
                ST_CALC: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) state <= ST_FIN;
                end
                default: begin
                    result_q <= sel;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.w_en   = done_q;
    assign bus.result = result_q;
    assign bus.w_addr = w_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module  : tb_mul_div_unit
// Brief   : Directed-vector scoreboard bench for mul_div_unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mul_div_unit;
    import otter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mul_div_unit_if bus();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  addr;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the unit signals completion.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            done_seen++;
            check("w_en", 32'(bus.w_en), 32'd1);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %h at cycle %0d expected no done",
                         bus.result, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check({e.name, "_result"}, bus.result, e.res);
                check({e.name, "_w_addr"}, 32'(bus.w_addr), 32'(e.addr));
                check({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] res, input string name);
        bus.start   = 1'b1;
        bus.funct3  = f;
        bus.op_a    = a;
        bus.op_b    = b;
        bus.rd_addr = rd;
        @(posedge clk);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.funct3  = ~f;
        bus.op_a    = ~a;
        bus.op_b    = 32'h1234_5678;
        bus.rd_addr = ~rd;
        q.push_back('{res: res, addr: rd, cyc: cyc + MDU_LATENCY, name: name});
        repeat (MDU_LATENCY + 1) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.start   = 1'b0;
        bus.funct3  = 3'd0;
        bus.op_a    = 32'd0;
        bus.op_b    = 32'd0;
        bus.rd_addr = 5'd0;

        repeat (3) @(negedge clk);
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_done",   32'(bus.done),   32'd0);
        check("rst_w_en",   32'(bus.w_en),   32'd0);
        check("rst_result", bus.result,      32'd0);
        check("rst_w_addr", 32'(bus.w_addr), 32'd0);

        rst = 1'b0;
        issue(F3_MUL,    32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, "mul_neg");
        issue(F3_MUL,    32'h1234_5678, 32'h0000_0010, 5'd6,  32'h2345_6780, "mul_shift");
        issue(F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, "mulh");
        issue(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, "mulhu");
        issue(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFF, "mulhsu");
        issue(F3_DIV,    32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, "div_neg");
        issue(F3_REM,    32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, "rem_neg");
        issue(F3_REM,    32'd7,         32'hFFFF_FFFE, 5'd12, 32'h0000_0001, "rem_negdiv");
        issue(F3_DIVU,   32'hFFFF_FFFF, 32'd16,        5'd13, 32'h0FFF_FFFF, "divu");
        issue(F3_DIVU,   32'd100,       32'd7,         5'd14, 32'd14,        "divu_small");
        issue(F3_REMU,   32'd100,       32'd7,         5'd15, 32'd2,         "remu_small");
        issue(F3_DIV,    32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, "div_zero");
        issue(F3_REMU,   32'd5,         32'd0,         5'd17, 32'd5,         "remu_zero");
        issue(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, "div_ovf");
        issue(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'd0,         "rem_ovf_x0");

        // start held high for 40 cycles: one completion in that window
        base        = done_seen;
        bus.start   = 1'b1;
        bus.funct3  = F3_MUL;
        bus.op_a    = 32'd3;
        bus.op_b    = 32'd5;
        bus.rd_addr = 5'd9;
        q.push_back('{res: 32'd15, addr: 5'd9, cyc: cyc + 1 + MDU_LATENCY, name: "hold"});
        repeat (40) @(negedge clk);
        check("hold_done_count", 32'(done_seen - base), 32'd1);
        bus.start = 1'b0;
        rst       = 1'b1;
        #1;
        check("hold_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the middle of an operation aborts it
        issue(F3_MULHU, 32'hDEAD_BEEF, 32'h0000_0003, 5'd20, 32'h0000_0002, "pre_abort");
        base        = done_seen;
        bus.start   = 1'b1;
        bus.funct3  = F3_DIVU;
        bus.op_a    = 32'd1000;
        bus.op_b    = 32'd3;
        bus.rd_addr = 5'd21;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy",   32'(bus.busy),   32'd0);
        check("abort_result", bus.result,      32'd0);
        check("abort_done",   32'(bus.done),   32'd0);
        check("abort_w_addr", 32'(bus.w_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", 32'(done_seen - base), 32'd0);

        issue(F3_DIVU, 32'd1000, 32'd3, 5'd22, 32'd333, "after_reset");

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
